// File: rtl/cb_router_if.sv
// Handshake bundle for the counted-branch router.
// The upstream port, the N downstream ports and the status outputs.
interface cb_router_if #(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int DEPTH = 2
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          CB_Send_in;
  logic [W-1:0]  CB_Data_in;
  logic [SW-1:0] CB_Br_in;
  logic          CB_Bcast_in;
  logic          CB_Ack_out;
  logic [N-1:0]  CB_Send_out;
  logic [W-1:0]  CB_Data_out;
  logic [N-1:0]  CB_Ack_in;
  logic [CW-1:0] CB_Count;
  logic          CB_Err;

  modport slave (
    input  CB_Send_in, CB_Data_in, CB_Br_in,
    input  CB_Bcast_in, CB_Ack_in,
    output CB_Ack_out, CB_Send_out, CB_Data_out,
    output CB_Count, CB_Err
  );

  modport master (
    output CB_Send_in, CB_Data_in, CB_Br_in,
    output CB_Bcast_in, CB_Ack_in,
    input  CB_Ack_out, CB_Send_out, CB_Data_out,
    input  CB_Count, CB_Err
  );
endinterface

// File: rtl/cb_router.sv
// Token router: FIFO of {data, select, bcast}; head goes to one
// channel or, for broadcast, to every channel before it pops.
module cb_router #(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int DEPTH = 2
) (
  input  logic        CP,
  input  logic        MR,
  cb_router_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     data_q [DEPTH];
  logic [SW-1:0]    sel_q  [DEPTH];
  logic [DEPTH-1:0] bc_q;

  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          err_q, err_d;

  logic          empty, full, ack_up;
  logic          take, keep, pop, head_bc;
  logic [N-1:0]  send, hit;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    ack_up  = !full && !MR;
    take    = bus.CB_Send_in && ack_up;
    keep    = take && (bus.CB_Bcast_in ||
              (32'(bus.CB_Br_in) < N));
    head_bc = bc_q[rp_q];
    send    = '0;
    if (!empty) begin
      if (head_bc) send = ~done_q;
      else         send = N'(1) << sel_q[rp_q];
    end
    hit = send & bus.CB_Ack_in;
    pop = 1'b0;
    if (!empty) begin
      if (head_bc) pop = &(done_q | bus.CB_Ack_in);
      else         pop = |hit;
    end
    // done only accumulates while a broadcast head is waiting
    done_d = done_q;
    if (pop)                  done_d = '0;
    else if (!empty && head_bc) done_d = done_q | hit;
    rp_d  = pop  ? rp_q + PW'(1) : rp_q;
    wp_d  = keep ? wp_q + PW'(1) : wp_q;
    cnt_d = cnt_q + CW'(keep) - CW'(pop);
    err_d = err_q | (take && !keep);
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      rp_q   <= '0;
      wp_q   <= '0;
      cnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rp_q   <= rp_d;
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge CP) begin
    if (keep) begin
      data_q[wp_q] <= bus.CB_Data_in;
      sel_q[wp_q]  <= bus.CB_Br_in;
      bc_q[wp_q]   <= bus.CB_Bcast_in;
    end
  end

  assign bus.CB_Ack_out  = ack_up;
  assign bus.CB_Send_out = send;
  assign bus.CB_Data_out = empty ? '0 : data_q[rp_q];
  assign bus.CB_Count    = cnt_q;
  assign bus.CB_Err      = err_q;
endmodule

// File: tb/tb_cb_router.sv
// Random and directed stimulus for cb_router with a queue-based
// reference model; outputs compared every falling edge.
module tb_cb_router;
  localparam int W     = 8;
  localparam int N     = 3;
  localparam int DEPTH = 2;

  logic CP = 1'b0;
  logic MR;
  always #5 CP = ~CP;

  cb_router_if #(.W(W), .N(N), .DEPTH(DEPTH)) bus ();

  cb_router #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .CP  (CP),
    .MR  (MR),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] owed;
  } tok_t;

  tok_t q[$];
  bit   err_m;
  bit   chk_en;
  int   pass_n;
  int   tot_n;

  task automatic chk(string nm, int act, int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Reference: each held token owes a set of channels; it leaves
  // once every owed channel has taken it.
  always @(posedge CP or posedge MR) begin
    int sz;
    tok_t t;
    if (MR) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      sz = q.size();
      if (sz > 0) begin
        t = q[0];
        t.owed = t.owed & ~bus.CB_Ack_in;
        if (t.owed == '0) void'(q.pop_front());
        else q[0] = t;
      end
      if (bus.CB_Send_in && sz < DEPTH) begin
        t.d = bus.CB_Data_in;
        if (bus.CB_Bcast_in) begin
          t.owed = '1;
          q.push_back(t);
        end else if (int'(bus.CB_Br_in) < N) begin
          t.owed = '0;
          t.owed[bus.CB_Br_in] = 1'b1;
          q.push_back(t);
        end else begin
          err_m = 1'b1;
        end
      end
    end
  end

  always @(negedge CP) begin
    int es, ed;
    if (chk_en) begin
      es = 0;
      ed = 0;
      if (q.size() > 0) begin
        es = int'(q[0].owed);
        ed = int'(q[0].d);
      end
      chk("send_out", int'(bus.CB_Send_out), es);
      chk("data_out", int'(bus.CB_Data_out), ed);
      chk("count", int'(bus.CB_Count), q.size());
      chk("ack_out", int'(bus.CB_Ack_out),
          int'(!MR && q.size() < DEPTH));
      chk("err", int'(bus.CB_Err), int'(err_m));
    end
  end

  task automatic drive(bit s, int d, int br, bit bc);
    bus.CB_Send_in  = s;
    bus.CB_Data_in  = W'(d);
    bus.CB_Br_in    = 2'(br);
    bus.CB_Bcast_in = bc;
  endtask

  // called at a falling edge; returns at a falling edge
  task automatic send(int d, int br, bit bc);
    int n;
    n = 0;
    drive(1'b1, d, br, bc);
    while (!bus.CB_Ack_out && n < 50) begin
      @(negedge CP);
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    @(negedge CP);
    drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic rst_now();
    #3 MR = 1'b1;
    #1;
    chk("rst_send", int'(bus.CB_Send_out), 0);
    chk("rst_data", int'(bus.CB_Data_out), 0);
    chk("rst_count", int'(bus.CB_Count), 0);
    chk("rst_ack", int'(bus.CB_Ack_out), 0);
    chk("rst_err", int'(bus.CB_Err), 0);
    @(negedge CP);
    #3 MR = 1'b0;
    @(negedge CP);
  endtask

  initial begin
    MR = 1'b1;
    chk_en = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    bus.CB_Ack_in = '0;
    #1;
    chk("init_count", int'(bus.CB_Count), 0);
    chk("init_send", int'(bus.CB_Send_out), 0);
    chk("init_ack", int'(bus.CB_Ack_out), 0);
    chk("init_err", int'(bus.CB_Err), 0);
    @(negedge CP);
    @(negedge CP);
    MR = 1'b0;
    chk_en = 1'b1;
    @(negedge CP);

    // unicast to ch1 with its ack already high
    bus.CB_Ack_in = 3'b010;
    send(8'h5A, 1, 1'b0);
    repeat (2) @(negedge CP);

    // staggered broadcast: ch0, ch2, then ch1
    bus.CB_Ack_in = '0;
    send(8'h33, 0, 1'b1);
    bus.CB_Ack_in = 3'b001;
    @(negedge CP);
    bus.CB_Ack_in = 3'b100;
    @(negedge CP);
    bus.CB_Ack_in = '0;
    @(negedge CP);
    bus.CB_Ack_in = 3'b010;
    @(negedge CP);
    bus.CB_Ack_in = '0;

    // broadcast taken by all channels on one edge
    send(8'hC4, 0, 1'b1);
    bus.CB_Ack_in = 3'b111;
    @(negedge CP);
    bus.CB_Ack_in = '0;

    // fill, hold a third token, then release one pop
    send(8'h11, 0, 1'b0);
    send(8'h22, 2, 1'b0);
    drive(1'b1, 8'h44, 1, 1'b0);
    repeat (3) @(negedge CP);
    bus.CB_Ack_in = 3'b001;
    @(negedge CP);
    bus.CB_Ack_in = '0;
    @(negedge CP);
    drive(1'b0, 0, 0, 1'b0);
    bus.CB_Ack_in = 3'b110;
    repeat (3) @(negedge CP);
    bus.CB_Ack_in = '0;

    // out-of-range select is swallowed and flagged
    send(8'h77, 3, 1'b0);
    repeat (2) @(negedge CP);

    // reset in the middle of a broadcast
    send(8'h99, 0, 1'b1);
    bus.CB_Ack_in = 3'b001;
    @(negedge CP);
    bus.CB_Ack_in = '0;
    rst_now();
    bus.CB_Ack_in = 3'b100;
    send(8'hE1, 2, 1'b0);
    @(negedge CP);
    bus.CB_Ack_in = '0;

    // push and pop on the same edge at count 1
    send(8'hA0, 0, 1'b0);
    drive(1'b1, 8'hB0, 2, 1'b0);
    bus.CB_Ack_in = 3'b001;
    @(negedge CP);
    drive(1'b0, 0, 0, 1'b0);
    bus.CB_Ack_in = 3'b100;
    @(negedge CP);
    bus.CB_Ack_in = '0;
    @(negedge CP);

    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      bus.CB_Ack_in = N'($urandom);
      if ($urandom_range(0, 199) == 0) rst_now();
      else @(negedge CP);
    end

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/cb_router.md
CB_ROUTER -- requirements
Module: cb_router

Interface
REQ-001 Parameter W, default 8, data token width in bits (W >= 1).
REQ-002 Parameter N, default 2, number of output channels (2..16); SW = clog2(N).
REQ-003 Parameter DEPTH, default 2, token FIFO depth (power of 2, >= 2); CW = clog2(DEPTH)+1.
REQ-004 Clocking SHALL be exactly: one clock; the reset is asynchronous and active-high.
REQ-005 CP  input  1  clock; all state changes on its rising edge.
REQ-006 MR  input  1  master reset; asynchronous, active-high.
REQ-007 CB_Send_in  input  1  upstream token valid.
REQ-008 CB_Data_in  input  W  upstream token data.
REQ-009 CB_Br_in  input  SW  branch select, sampled with the token.
REQ-010 CB_Bcast_in  input  1  broadcast mode: copy the token to all N outputs.
REQ-011 CB_Ack_out  output  1  upstream ready.
REQ-012 CB_Send_out  output  N  per-channel downstream valid.
REQ-013 CB_Data_out  output  W  head token data, shared by all channels.
REQ-014 CB_Ack_in  input  N  per-channel downstream ready.
REQ-015 CB_Count  output  CW  number of tokens held.
REQ-016 CB_Err  output  1  sticky flag: out-of-range branch select seen.

Function
REQ-017 All handshakes SHALL be active-high; a transfer occurs on a CP edge where Send and Ack are both 1.
REQ-018 CB_Ack_out SHALL be 1 exactly when Count < DEPTH and MR = 0.
REQ-019 On an upstream transfer with CB_Bcast_in = 1, or with CB_Br_in < N, {data, select, bcast} SHALL be pushed at the tail.
REQ-020 On an upstream transfer with CB_Bcast_in = 0 and CB_Br_in >= N, the token SHALL be consumed but not pushed, and CB_Err SHALL set.
REQ-021 CB_Err SHALL stay set until MR.
REQ-022 With the FIFO empty, CB_Send_out SHALL be all-zero and CB_Data_out SHALL be 0.
REQ-023 Non-empty, unicast head: CB_Send_out SHALL be one-hot at the head select; CB_Data_out SHALL be the head data.
REQ-024 Non-empty, broadcast head: CB_Send_out SHALL equal ~done, where done is an N-bit register of channels that have already taken the head.
REQ-025 Unicast head SHALL pop on the edge where CB_Ack_in[select] = 1; Ack on other channels SHALL be ignored.
REQ-026 Broadcast head: on each edge, done SHALL OR in (CB_Send_out & CB_Ack_in).
REQ-027 Broadcast head SHALL pop on the edge where (done | CB_Ack_in) is all-ones, including all channels acking on the same edge; done SHALL clear to 0 on that pop.
REQ-028 Latency: a token pushed at edge k into an empty FIFO SHALL be presented on CB_Send_out in the cycle after edge k. There is no same-cycle bypass.
REQ-029 Simultaneous push and pop SHALL be allowed whenever not full; Count SHALL then stay unchanged.
REQ-030 When full, there SHALL be no push, even if a pop occurs on the same edge.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 Count SHALL be incremented per push and decremented per pop, and SHALL never exceed DEPTH or go below 0.
REQ-033 Tokens SHALL leave in arrival order, regardless of channel; a stalled head blocks all channels.
REQ-034 Once presented, CB_Send_out bits and CB_Data_out SHALL stay stable until acked or until MR.

Reset
REQ-035 While MR = 1, the following SHALL hold immediately, without waiting for CP:
- pointers = 0, Count = 0, done = 0, CB_Err = 0
- CB_Send_out = 0, CB_Data_out = 0, CB_Ack_out = 0
REQ-036 MR asserted mid-operation SHALL discard all held tokens, including a partially delivered broadcast.
REQ-037 After MR deasserts, CB_Ack_out SHALL be 1 from the next cycle.
REQ-038 FIFO data storage need not be reset.

Verification
REQ-039 Unicast routing, N=2:
- stimulus: push data 0x5A with Br=1, CB_Ack_in=2'b10
- response: next cycle CB_Send_out=2'b10 and CB_Data_out=0x5A; pop on the following edge; Count returns to 0.
REQ-040 Broadcast with staggered acks, N=4:
- stimulus: push 0x33 with Bcast=1; ack ch0 then ch2 then {ch1,ch3}
- response: CB_Send_out goes 1111 -> 1110 -> 1010 -> pop; Count returns to 0.
REQ-041 Full/backpressure, DEPTH=2:
- stimulus: push 3 tokens with CB_Ack_in=0
- response: CB_Ack_out=0 after 2 pushes; the 3rd token is held upstream; it is accepted on the edge after the first pop.
REQ-042 Out-of-range select, N=3:
- stimulus: push with Br=3
- response: token accepted, Count stays 0, CB_Err=1 until MR.
REQ-043 Reset mid-broadcast:
- stimulus: assert MR between CP edges after one channel has acked
- response: CB_Send_out=0 and Count=0 immediately; after release, a new token routes normally with done=0.
REQ-044 Push and pop on the same edge:
- stimulus: Count=1, upstream push while the head is acked
- response: Count stays 1; the new token is presented next cycle.
